bit_stream_serializer: RTL and testbench
========================================

// Module: bit_stream_serializer
// PURPOSE
//  Upstream feeder for the serial pattern detectors. Accepts parallel words over a
//  valid/ready handshake and shifts them out one bit per bit period, set by a
//  clock divider. bit_out drives detector data_in; bit_en (1-cycle strobe) drives
//  detector en. Back-to-back words stream with no gap.
// PARAMETERS
//  WORD_W    8  bits per loaded word; legal range >= 2
//  TICK_DIV  4  clk cycles per bit period; legal range >= 1 (1 = one bit per clk)
//  MSB_FIRST 1  1: shift out load_data[WORD_W-1] first; 0: load_data[0] first
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  load_valid in   1       upstream has a word on load_data
//  load_ready out  1       block can accept a word this cycle
//  load_data  in   WORD_W  parallel word to serialize
//  bit_out    out  1       current serial bit (to detector data_in)
//  bit_en     out  1       1-cycle strobe: consume bit_out now (to detector en)
//  busy       out  1       high while a word is being shifted
//  word_done  out  1       1-cycle pulse, same cycle as the last bit_en of a word
// BEHAVIOUR
//  - Reset (first posedge with reset=1): state=IDLE, shift reg=0, divider=0,
//    bit counter=0; bit_out=0, bit_en=0, busy=0, word_done=0. load_ready is forced
//    to 0 while reset=1 and returns to 1 on the first cycle after release.
//  - FSM: IDLE, SHIFT. busy = (state==SHIFT).
//  - IDLE: load_ready=1. Transfer on load_valid&&load_ready at cycle T. Capture
//    load_data, bit counter=WORD_W, divider=0, then SHIFT from T+1.
//  - SHIFT: divider counts 0..TICK_DIV-1 and wraps.
//    bit_en = (state==SHIFT && divider==TICK_DIV-1), decoded from registers.
//  - After each bit_en, the shift reg shifts one place toward the output end,
//    filling with 0. bit counter decrements.
//  - bit_out = head of the shift reg (MSB_FIRST ? sr[WORD_W-1] : sr[0]).
//    It is stable for the whole bit period and changes only in the cycle after a
//    bit_en, or after a load.
//  - Timing: bit k (k=1..WORD_W) has its bit_en at cycle T + k*TICK_DIV.
//    word_done is high in the same cycle as bit WORD_W's bit_en.
//  - Last-bit cycle (bit counter==1 && bit_en): load_ready=1.
//    - If load_valid: the new word is captured, divider=0, and the block stays in
//      SHIFT. The next bit_en is exactly TICK_DIV cycles later, giving a gapless
//      stream.
//    - Else: go to IDLE. bit_out is 0 (shifted-out zeros).
//  - In SHIFT, outside the last-bit cycle: load_ready=0. load_valid is ignored and
//    load_data is not sampled.
//  - Reset asserted mid-word: the word is discarded and no further bit_en pulses
//    occur. Outputs take their reset values.
//  - Counter widths: $clog2(TICK_DIV) and $clog2(WORD_W+1), each minimum 1 bit.
//    No arithmetic overflow at any legal parameter value.
//  - bit_en and word_done are never high in IDLE. At most one bit_en per
//    TICK_DIV cycles.
// TESTING
//  1. WORD_W=8, TICK_DIV=4, load 8'b0110_0110 at T -> bit_en at T+4,8,..,32;
//     bits 0,1,1,0,0,1,1,0; word_done at T+32. Downstream 0110 detector pulses
//     twice.
//  2. TICK_DIV=1, load_valid held high with 8'hA5 then 8'h3C -> 16 consecutive
//     bit_en cycles with no gap. load_ready high only in IDLE and in each
//     last-bit cycle.
//  3. load_valid=1 with 8'hFF during bit 3 of a word in progress -> load_ready=0,
//     word not taken, remaining bits of the original word unchanged.
//  4. reset pulsed for 1 cycle after bit 3's bit_en -> bit_en stays 0, busy=0,
//     load_ready=0 during reset and 1 the cycle after. A new load of 8'h0F then
//     serializes cleanly from bit 1.
//  5. MSB_FIRST=0, load 8'h06 -> bits 0,1,1,0,0,0,0,0.
//  6. TICK_DIV=3: check that bit_out never changes except in the cycle after a
//     bit_en or a load. word_done equals the AND of bit_en and last-bit across
//     random back-to-back traffic.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the pattern detectors: words arrive over valid/ready
// and leave one bit per TICK_DIV clocks, with gapless back-to-back streaming.
module bit_stream_serializer #(
   parameter int WORD_W    = 8,
   parameter int TICK_DIV  = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WORD_W-1:0] load_data,
   output logic              bit_out,
   output logic              bit_en,
   output logic              busy,
   output logic              word_done
);

   // Handshake: a word transfers on any posedge where load_valid && load_ready;
   // load_ready never depends on load_valid, and load_data is sampled only then.

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [WORD_W-1:0] sr;
   logic [DIV_W-1:0]  div;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] sr_shifted;
   logic              last_bit;
   logic              take;

   assign bit_en     = (state == SHIFT) && (div == DIV_LAST);
   assign last_bit   = bit_en && (cnt == CNT_ONE);
   assign word_done  = last_bit;
   assign busy       = (state == SHIFT);
   assign load_ready = !reset && ((state == IDLE) || last_bit);
   assign take       = load_valid && load_ready;

   // The head of the shift register is the output bit; zeros fill in behind it.
   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign bit_out    = sr[WORD_W-1];
         assign sr_shifted = {sr[WORD_W-2:0], 1'b0};
      end else begin : g_lsb
         assign bit_out    = sr[0];
         assign sr_shifted = {1'b0, sr[WORD_W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sr    <= '0;
         div   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  sr    <= load_data;
                  cnt   <= CNT_FULL;
                  div   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (take) begin
                  // take only happens in the last-bit cycle: reload and keep streaming
                  sr  <= load_data;
                  cnt <= CNT_FULL;
                  div <= '0;
               end else if (bit_en) begin
                  sr  <= sr_shifted;
                  cnt <= cnt - CNT_ONE;
                  div <= '0;
                  if (last_bit) state <= IDLE;
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: four parameterizations checked cycle by cycle
// against a word-timeline model, plus directed scenario checks.
module tb_bit_stream_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] lv = '0;
   logic [7:0] ld [4];
   logic [3:0] lr, bo, be, bz, wd;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   initial forever #5 clk = ~clk;

   bit_stream_serializer #(.WORD_W(8), .TICK_DIV(4), .MSB_FIRST(1)) u0 (
      .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
      .bit_out(bo[0]), .bit_en(be[0]), .busy(bz[0]), .word_done(wd[0]));
   bit_stream_serializer #(.WORD_W(8), .TICK_DIV(1), .MSB_FIRST(1)) u1 (
      .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
      .bit_out(bo[1]), .bit_en(be[1]), .busy(bz[1]), .word_done(wd[1]));
   bit_stream_serializer #(.WORD_W(8), .TICK_DIV(3), .MSB_FIRST(1)) u2 (
      .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2]),
      .bit_out(bo[2]), .bit_en(be[2]), .busy(bz[2]), .word_done(wd[2]));
   bit_stream_serializer #(.WORD_W(8), .TICK_DIV(4), .MSB_FIRST(0)) u3 (
      .clk(clk), .reset(reset), .load_valid(lv[3]), .load_ready(lr[3]), .load_data(ld[3]),
      .bit_out(bo[3]), .bit_en(be[3]), .busy(bz[3]), .word_done(wd[3]));

   function automatic int td_of(input int i);
      case (i)
         1:       return 1;
         2:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic bit mf_of(input int i);
      return (i != 3);
   endfunction

   // bit k (1..8) of a word in transmission order
   function automatic logic bit_of(input logic [7:0] w, input int k, input bit mf);
      return mf ? w[8-k] : w[k-1];
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   // Model: each instance is either idle or carrying one word accepted at cycle m_t0
   bit         m_on = 1'b0;
   bit         m_busy [4];
   int         m_t0   [4];
   logic [7:0] m_w    [4];
   bit         rx_q [4][$];
   int         en_q [4][$];

   function automatic bit m_ready(input int i);
      return !reset && (!m_busy[i] || (cyc - m_t0[i]) == 8 * td_of(i));
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) m_busy[i] = 1'b0;
         else if (m_on) begin
            if (lv[i] && m_ready(i)) begin
               m_busy[i] = 1'b1;
               m_t0[i]   = cyc;
               m_w[i]    = ld[i];
            end else if (m_busy[i] && (cyc - m_t0[i]) == 8 * td_of(i)) begin
               m_busy[i] = 1'b0;
            end
         end
      end
      if (reset) m_on = 1'b1;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (m_on) begin
            logic e_en, e_bit, e_done, e_busy;
            e_en = 0; e_bit = 0; e_done = 0; e_busy = 0;
            if (m_busy[i]) begin
               int d, k;
               d      = cyc - m_t0[i];
               k      = (d - 1) / td_of(i) + 1;
               e_busy = 1;
               e_en   = (d % td_of(i)) == 0;
               e_bit  = bit_of(m_w[i], k, mf_of(i));
               e_done = e_en && (k == 8);
            end
            chk("bit_en", i, be[i], e_en);
            chk("bit_out", i, bo[i], e_bit);
            chk("word_done", i, wd[i], e_done);
            chk("busy", i, bz[i], e_busy);
            if (be[i] === 1'b1) begin
               rx_q[i].push_back(bo[i]);
               en_q[i].push_back(cyc);
            end
         end
      end
      #1;
      for (int i = 0; i < 4; i++)
         if (m_on) chk("load_ready", i, lr[i], m_ready(i));
   end

   // Called with lv[i] already high at a negedge; returns at the negedge after the transfer.
   task automatic wait_ready(input int i, output int t);
      t = -1;
      for (int n = 0; n < 500; n++) begin
         #1;
         if (lr[i] === 1'b1) begin
            t = cyc;
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      chk("ready_timeout", i, lr[i], 1);
   endtask

   task automatic wait_done(input int i);
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         #1;
         if (wd[i] === 1'b1) return;
      end
      chk("done_timeout", i, wd[i], 1);
   endtask

   task automatic check_rx(input int i, input logic [7:0] w, input int t);
      chk("rx_count", i, rx_q[i].size(), 8);
      for (int k = 1; k <= 8; k++) begin
         if (k <= rx_q[i].size()) begin
            chk("rx_bit", i, rx_q[i][k-1], bit_of(w, k, mf_of(i)));
            chk("en_cycle", i, en_q[i][k-1], t + k * td_of(i));
         end
      end
      rx_q[i].delete();
      en_q[i].delete();
   endtask

   initial begin
      int t, t2, hits;
      logic [7:0] w;
      logic [7:0] wl [$];
      for (int i = 0; i < 4; i++) ld[i] = '0;

      // reset and release
      repeat (2) @(negedge clk);
      #1;
      chk("ready_in_reset", 0, lr[0], 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("ready_after_reset", 0, lr[0], 1);

      // 0110_0110 MSB first, TICK_DIV=4; a 0110 detector should see two hits
      @(negedge clk);
      lv[0] = 1'b1; ld[0] = 8'b0110_0110;
      wait_ready(0, t);
      lv[0] = 1'b0;
      wait_done(0);
      hits = 0;
      for (int j = 3; j < rx_q[0].size(); j++)
         if ({rx_q[0][j-3], rx_q[0][j-2], rx_q[0][j-1], rx_q[0][j]} == 4'b0110) hits++;
      chk("det_0110", 0, hits, 2);
      check_rx(0, 8'b0110_0110, t);

      // TICK_DIV=1, valid held high: A5 then 3C with no gap
      @(negedge clk);
      lv[1] = 1'b1; ld[1] = 8'hA5;
      wait_ready(1, t);
      ld[1] = 8'h3C;
      wait_ready(1, t2);
      lv[1] = 1'b0;
      chk("b2b_accept", 1, t2, t + 8);
      wait_done(1);
      chk("b2b_count", 1, rx_q[1].size(), 16);
      for (int j = 0; j < 16 && j < rx_q[1].size(); j++) begin
         chk("b2b_bit", 1, rx_q[1][j], (j < 8) ? bit_of(8'hA5, j + 1, 1) : bit_of(8'h3C, j - 7, 1));
         chk("b2b_en_cycle", 1, en_q[1][j], t + 1 + j);
      end
      rx_q[1].delete(); en_q[1].delete();

      // a competing 8'hFF offered during bit 3 must be ignored
      w = 8'($urandom);
      @(negedge clk);
      lv[0] = 1'b1; ld[0] = w;
      wait_ready(0, t);
      lv[0] = 1'b0;
      repeat (8) @(negedge clk);
      lv[0] = 1'b1; ld[0] = 8'hFF;
      repeat (3) begin
         #1;
         chk("busy_not_ready", 0, lr[0], 0);
         @(negedge clk);
      end
      lv[0] = 1'b0;
      wait_done(0);
      check_rx(0, w, t);

      // reset pulse right after bit 3, then a clean 8'h0F
      w = 8'($urandom);
      @(negedge clk);
      lv[0] = 1'b1; ld[0] = w;
      wait_ready(0, t);
      lv[0] = 1'b0;
      for (int n = 0; n < 200 && en_q[0].size() < 3; n++) @(negedge clk);
      chk("bit3_reached", 0, en_q[0].size(), 3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("no_en_after_reset", 0, en_q[0].size(), 3);
      rx_q[0].delete(); en_q[0].delete();
      lv[0] = 1'b1; ld[0] = 8'h0F;
      wait_ready(0, t);
      lv[0] = 1'b0;
      wait_done(0);
      check_rx(0, 8'h0F, t);

      // LSB first: 8'h06 -> 0,1,1,0,0,0,0,0
      @(negedge clk);
      lv[3] = 1'b1; ld[3] = 8'h06;
      wait_ready(3, t);
      lv[3] = 1'b0;
      wait_done(3);
      check_rx(3, 8'h06, t);

      // TICK_DIV=3 random traffic with occasional idle gaps
      @(negedge clk);
      for (int n = 0; n < 20; n++) begin
         int gap;
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         if (gap > 0) begin
            lv[2] = 1'b0;
            repeat (gap) @(negedge clk);
         end
         w = 8'($urandom);
         lv[2] = 1'b1; ld[2] = w;
         wait_ready(2, t);
         wl.push_back(w);
      end
      lv[2] = 1'b0;
      wait_done(2);
      chk("rand_count", 2, rx_q[2].size(), 8 * wl.size());
      for (int j = 0; j < rx_q[2].size() && j < 8 * wl.size(); j++)
         chk("rand_bit", 2, rx_q[2][j], bit_of(wl[j/8], (j % 8) + 1, 1));
      for (int j = 1; j < en_q[2].size(); j++)
         chk("rand_en_spacing", 2, (en_q[2][j] - en_q[2][j-1]) >= 3, 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
